// File: rtl/xoshiro128pp_jump_ctrl.sv
// xoshiro128++ jump / long_jump controller.
// Sits between the user and the PRNG state block. When idle, the user's
// advance and seed controls pass straight through to the PRNG. During a
// jump, the controller walks the 128-bit jump polynomial one bit per cycle.
// For every set bit it XOR-accumulates the PRNG's current state. The PRNG
// advances on every cycle, whether the bit is set or not. At the end, the
// accumulated state is loaded back into the PRNG through its seed port.
module xoshiro128pp_jump_ctrl #(
    parameter logic [127:0] JUMP_K = 128'h77f2db5b_6fa035c3_f542d2d3_8764000b,
    parameter logic [127:0] LONG_K = 128'h1c580662_ccf5a0ef_0b6f099f_b523952e
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cg,
    input  logic        i_seedValid,
    input  logic [31:0] i_seedS0,
    input  logic [31:0] i_seedS1,
    input  logic [31:0] i_seedS2,
    input  logic [31:0] i_seedS3,
    input  logic        i_jumpReq,
    input  logic        i_jumpLong,
    input  logic [31:0] i_s0,
    input  logic [31:0] i_s1,
    input  logic [31:0] i_s2,
    input  logic [31:0] i_s3,
    output logic        o_cg,
    output logic        o_seedValid,
    output logic [31:0] o_seedS0,
    output logic [31:0] o_seedS1,
    output logic [31:0] o_seedS2,
    output logic [31:0] o_seedS3,
    output logic        o_busy,
    output logic        o_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [6:0]  k;
    logic        tbl_long;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [31:0] a3;
    logic        done;
    logic        start;
    logic        take_bit;

    // Polynomial bit for the current step: bit 0 of word 0 comes first.
    always_comb begin
        take_bit = tbl_long ? LONG_K[k] : JUMP_K[k];
    end

    // Next-state and output decode; idle is a transparent pass-through.
    always_comb begin
        state_next  = state;
        start       = 1'b0;
        o_cg        = i_cg;
        o_seedValid = i_seedValid;
        o_seedS0    = i_seedS0;
        o_seedS1    = i_seedS1;
        o_seedS2    = i_seedS2;
        o_seedS3    = i_seedS3;
        o_busy      = 1'b0;
        case (state)
            IDLE: begin
                if (i_jumpReq) begin
                    start      = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                o_cg        = 1'b1;
                o_seedValid = 1'b0;
                o_seedS0    = a0;
                o_seedS1    = a1;
                o_seedS2    = a2;
                o_seedS3    = a3;
                o_busy      = 1'b1;
                if (k == 7'd127) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                // The seed load wins over the advance inside the PRNG.
                // o_cg stays high only to keep the interface uniform while busy.
                o_cg        = 1'b1;
                o_seedValid = 1'b1;
                o_seedS0    = a0;
                o_seedS1    = a1;
                o_seedS2    = a2;
                o_seedS3    = a3;
                o_busy      = 1'b1;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign o_done = done;

    // State register; reset aborts any jump in flight without a load.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Step counter, table select, accumulators and done pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            k        <= 7'd0;
            tbl_long <= 1'b0;
            a0       <= 32'd0;
            a1       <= 32'd0;
            a2       <= 32'd0;
            a3       <= 32'd0;
            done     <= 1'b0;
        end else begin
            done <= (state == LOAD);
            if (start) begin
                tbl_long <= i_jumpLong;
                k        <= 7'd0;
                a0       <= 32'd0;
                a1       <= 32'd0;
                a2       <= 32'd0;
                a3       <= 32'd0;
            end else if (state == RUN) begin
                k <= k + 7'd1;
                // Accumulate the pre-advance state; the PRNG steps on this same edge.
                if (take_bit) begin
                    a0 <= a0 ^ i_s0;
                    a1 <= a1 ^ i_s1;
                    a2 <= a2 ^ i_s2;
                    a3 <= a3 ^ i_s3;
                end
            end
        end
    end

endmodule

// File: tb/tb_xoshiro128pp_jump_ctrl.sv
// Bench for xoshiro128pp_jump_ctrl. It contains a behavioural xoshiro128++
// state block that is driven by the controller's outputs. Expected jump
// results come from a C-style reference jump()/long_jump().
module tb_xoshiro128pp_jump_ctrl;

    logic        clk;
    logic        rst;
    logic        i_cg;
    logic        i_seedValid;
    logic [31:0] i_seedS0, i_seedS1, i_seedS2, i_seedS3;
    logic        i_jumpReq;
    logic        i_jumpLong;
    logic        o_cg;
    logic        o_seedValid;
    logic [31:0] o_seedS0, o_seedS1, o_seedS2, o_seedS3;
    logic        o_busy;
    logic        o_done;

    // PRNG state {s3,s2,s1,s0}
    logic [127:0] ps;

    int n_checks = 0;
    int n_fail   = 0;

    xoshiro128pp_jump_ctrl dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cg        (i_cg),
        .i_seedValid (i_seedValid),
        .i_seedS0    (i_seedS0),
        .i_seedS1    (i_seedS1),
        .i_seedS2    (i_seedS2),
        .i_seedS3    (i_seedS3),
        .i_jumpReq   (i_jumpReq),
        .i_jumpLong  (i_jumpLong),
        .i_s0        (ps[31:0]),
        .i_s1        (ps[63:32]),
        .i_s2        (ps[95:64]),
        .i_s3        (ps[127:96]),
        .o_cg        (o_cg),
        .o_seedValid (o_seedValid),
        .o_seedS0    (o_seedS0),
        .o_seedS1    (o_seedS1),
        .o_seedS2    (o_seedS2),
        .o_seedS3    (o_seedS3),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
        return (x << s) | (x >> (32 - s));
    endfunction

    // xoshiro128++ state transition
    function automatic logic [127:0] ref_step(input logic [127:0] st);
        logic [31:0] s0, s1, s2, s3, t;
        s0 = st[31:0]; s1 = st[63:32]; s2 = st[95:64]; s3 = st[127:96];
        t  = s1 << 9;
        s2 = s2 ^ s0;
        s3 = s3 ^ s1;
        s1 = s1 ^ s2;
        s0 = s0 ^ s3;
        s2 = s2 ^ t;
        s3 = rotl(s3, 11);
        return {s3, s2, s1, s0};
    endfunction

    // xoshiro128++ output for a given state
    function automatic logic [31:0] ref_out(input logic [127:0] st);
        return rotl(st[31:0] + st[127:96], 7) + st[31:0];
    endfunction

    // C reference jump()/long_jump()
    function automatic logic [127:0] ref_jump(input logic [127:0] st, input bit lng);
        logic [31:0] w [4];
        logic [127:0] acc;
        if (lng) w = '{32'hb523952e, 32'h0b6f099f, 32'hccf5a0ef, 32'h1c580662};
        else     w = '{32'h8764000b, 32'hf542d2d3, 32'h6fa035c3, 32'h77f2db5b};
        acc = '0;
        for (int i = 0; i < 4; i++) begin
            for (int b = 0; b < 32; b++) begin
                if (w[i][b]) acc = acc ^ st;
                st = ref_step(st);
            end
        end
        return acc;
    endfunction

    // Behavioural PRNG state block: seed load has priority over advance.
    always @(posedge clk) begin
        if (o_seedValid)  ps <= {o_seedS3, o_seedS2, o_seedS1, o_seedS0};
        else if (o_cg)    ps <= ref_step(ps);
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic seed_prng(input logic [31:0] a, b, c, d);
        i_seedValid = 1'b1;
        i_seedS0 = a; i_seedS1 = b; i_seedS2 = c; i_seedS3 = d;
        @(negedge clk);
        i_seedValid = 1'b0;
        i_seedS0 = '0; i_seedS1 = '0; i_seedS2 = '0; i_seedS3 = '0;
        check_eq("seed_state", ps, {d, c, b, a});
    endtask

    // Runs one jump from the negedge before the accept edge; optionally
    // hammers the user controls while the jump is in progress.
    task automatic run_jump(input string tag, input bit lng, input bit interfere);
        logic [127:0] exp, load_val;
        int busy_n, sv_n, sv_at;
        exp = ref_jump(ps, lng);
        load_val = '1;
        busy_n = 0; sv_n = 0; sv_at = 0;
        i_jumpReq = 1'b1;
        i_jumpLong = lng;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!o_busy) break;
            busy_n++;
            if (o_seedValid) begin
                sv_n++;
                sv_at = busy_n;
                load_val = {o_seedS3, o_seedS2, o_seedS1, o_seedS0};
            end
            if (interfere && busy_n == 10) begin
                i_seedValid = 1'b1; i_cg = 1'b1;
                i_seedS0 = 32'hdeadbeef; i_seedS1 = 32'hdeadbeef;
                i_seedS2 = 32'hdeadbeef; i_seedS3 = 32'hdeadbeef;
            end else if (!interfere || busy_n >= 20) begin
                i_jumpReq = 1'b0; i_seedValid = 1'b0; i_cg = 1'b0;
                i_seedS0 = '0; i_seedS1 = '0; i_seedS2 = '0; i_seedS3 = '0;
            end
        end
        i_jumpReq = 1'b0;
        check_eq({tag, "_busy_cycles"}, 128'(busy_n), 128'd129);
        check_eq({tag, "_seedvalid_count"}, 128'(sv_n), 128'd1);
        check_eq({tag, "_seedvalid_at"}, 128'(sv_at), 128'd129);
        check_eq({tag, "_load_value"}, load_val, exp);
        check_eq({tag, "_done_pulse"}, 128'(o_done), 128'd1);
        @(negedge clk);
        check_eq({tag, "_done_clear"}, 128'(o_done), 128'd0);
        check_eq({tag, "_no_rejump"}, 128'(o_busy), 128'd0);
        check_eq({tag, "_final_state"}, ps, exp);
    endtask

    initial begin
        logic [127:0] m;
        int done_n, busy_n;
        rst = 1'b1;
        i_cg = 1'b0; i_seedValid = 1'b0; i_jumpReq = 1'b0; i_jumpLong = 1'b0;
        i_seedS0 = '0; i_seedS1 = '0; i_seedS2 = '0; i_seedS3 = '0;
        repeat (2) @(negedge clk);
        check_eq("reset_busy", 128'(o_busy), 128'd0);
        check_eq("reset_done", 128'(o_done), 128'd0);
        check_eq("reset_cg", 128'(o_cg), 128'd0);
        rst = 1'b0;
        @(negedge clk);

        // Pass-through while idle
        i_cg = 1'b1; i_seedValid = 1'b1;
        i_seedS0 = 32'h11111111; i_seedS1 = 32'h22222222;
        i_seedS2 = 32'h33333333; i_seedS3 = 32'h44444444;
        #1;
        check_eq("pass_cg", 128'(o_cg), 128'd1);
        check_eq("pass_seedvalid", 128'(o_seedValid), 128'd1);
        check_eq("pass_seeds", {o_seedS3, o_seedS2, o_seedS1, o_seedS0},
                 128'h44444444_33333333_22222222_11111111);
        check_eq("pass_busy", 128'(o_busy), 128'd0);
        i_cg = 1'b0; i_seedValid = 1'b0;
        @(negedge clk);

        // jump() from {1,2,3,4}; first output of that seed is rotl(5,7)+1 = 641
        seed_prng(32'd1, 32'd2, 32'd3, 32'd4);
        check_eq("seed_first_output", 128'(ref_out(ps)), 128'd641);
        run_jump("jump", 1'b0, 1'b0);

        // long_jump() from {1,2,3,4}, then 16 outputs
        seed_prng(32'd1, 32'd2, 32'd3, 32'd4);
        run_jump("long_jump", 1'b1, 1'b0);
        m = ref_jump({32'd4, 32'd3, 32'd2, 32'd1}, 1'b1);
        i_cg = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("long_out%0d", i), 128'(ref_out(ps)), 128'(ref_out(m)));
            m = ref_step(m);
            @(negedge clk);
        end
        i_cg = 1'b0;
        @(negedge clk);

        // All-zero state is a fixed point
        seed_prng(32'd0, 32'd0, 32'd0, 32'd0);
        run_jump("zero", 1'b0, 1'b0);

        // User controls and a second request during RUN are ignored
        seed_prng(32'd1, 32'd2, 32'd3, 32'd4);
        run_jump("interfere", 1'b0, 1'b1);

        // Reset at k=40 aborts the jump
        seed_prng(32'd1, 32'd2, 32'd3, 32'd4);
        i_jumpReq = 1'b1;
        busy_n = 0;
        for (int c = 0; c < 60 && busy_n < 41; c++) begin
            @(negedge clk);
            if (o_busy) busy_n++;
            i_jumpReq = 1'b0;
        end
        check_eq("abort_reached_k40", 128'(busy_n), 128'd41);
        rst = 1'b1; i_cg = 1'b1;
        #1;
        check_eq("abort_busy", 128'(o_busy), 128'd0);
        check_eq("abort_cg_follows", 128'(o_cg), 128'd1);
        i_cg = 1'b0;
        #1;
        check_eq("abort_cg_follows_low", 128'(o_cg), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        done_n = 0; busy_n = 0;
        for (int c = 0; c < 140; c++) begin
            @(negedge clk);
            if (o_done) done_n++;
            if (o_busy) busy_n++;
        end
        check_eq("abort_no_done", 128'(done_n), 128'd0);
        check_eq("abort_no_busy", 128'(busy_n), 128'd0);
        seed_prng(32'd1, 32'd2, 32'd3, 32'd4);
        run_jump("after_abort", 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
